// File: rtl/writeback_pipe.sv
// writeback_pipe
//
// Final writeback stage of the pipeline. Accepted instructions produce a
// one-cycle register-file write on the following cycle. Instructions that
// send a row index to the graphics unit push it into a small FIFO, which
// drains through a valid/ready handshake.
//
// Optional feature: define WB_FWD_EN to add fwd_valid/fwd_addr/fwd_data,
// a combinational copy of the register-file write port for decode bypass.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   in_valid/in_ready upstream handshake; in_ready is low only when the
//                     row queue is full
//   in_data           result or getRow data
//   in_pc_plus_8      link value, selected when in_is_jal = 1
//   in_we, in_rd      register write request and destination
//   in_send_row       push in_row_idx into the row queue on accept
//   in_row_idx        row index to push
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   row_valid/row_ready/row_idx  row queue head handshake; row_idx is all
//                     ones while the queue is empty
//   row_q_count       number of entries held in the row queue
//   fwd_valid/fwd_addr/fwd_data  (WB_FWD_EN only) copy of rf write port
module writeback_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int IDX_W      = 5,
  parameter int ROWQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [DATA_W-1:0]             in_pc_plus_8,
  input  logic                          in_is_jal,
  input  logic                          in_we,
  input  logic [REG_W-1:0]              in_rd,
  input  logic                          in_send_row,
  input  logic [IDX_W-1:0]              in_row_idx,
  output logic                          rf_we,
  output logic [REG_W-1:0]              rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [IDX_W-1:0]              row_idx,
  output logic [$clog2(ROWQ_DEPTH):0]   row_q_count
`ifdef WB_FWD_EN
  ,
  output logic                          fwd_valid,
  output logic [REG_W-1:0]              fwd_addr,
  output logic [DATA_W-1:0]             fwd_data
`endif
);

  localparam int PTR_W = $clog2(ROWQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(ROWQ_DEPTH);

  logic              accept_p0;
  logic              push_p0;
  logic              pop_p0;
  logic              wr_en_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [IDX_W-1:0]  mem [ROWQ_DEPTH];

  // ---- stage p0: accept decision and writeback value select ----
  assign in_ready  = (count_q < DEPTH_C);
  assign accept_p0 = in_valid & in_ready;
  assign wdata_p0  = in_is_jal ? in_pc_plus_8 : in_data;
  // Register 0 is hard-wired; a write to it is dropped entirely so the
  // write port keeps presenting the previous address/data.
  assign wr_en_p0  = accept_p0 & in_we & (in_rd != '0);
  assign push_p0   = accept_p0 & in_send_row;
  assign pop_p0    = row_valid & row_ready;

  // ---- stage p1: registered register-file write port ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en_p0;
      if (wr_en_p0) begin
        rf_waddr <= in_rd;
        rf_wdata <= wdata_p0;
      end
    end
  end

  // ---- row queue control ----
  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_p0) tail_q <= tail_q + 1'b1;
      if (pop_p0)  head_q <= head_q + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is defined by count_q alone.
  always_ff @(posedge clk) begin
    if (rst && push_p0) mem[tail_q] <= in_row_idx;
  end

  assign row_q_count = count_q;
  assign row_valid   = (count_q != '0);
  assign row_idx     = row_valid ? mem[head_q] : '1;

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_writeback_pipe.sv
// tb_writeback_pipe
//
// Self-checking bench for writeback_pipe (default parameters). A directed
// vector table covers writeback select, register-0 suppression, queue
// fill/full/pop and push+pop; hand sequences cover pointer wrap and reset
// mid-traffic; a randomized phase is checked against a queue-based model.
module tb_writeback_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int IDX_W  = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_pc_plus_8;
  logic              in_is_jal;
  logic              in_we;
  logic [REG_W-1:0]  in_rd;
  logic              in_send_row;
  logic [IDX_W-1:0]  in_row_idx;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              row_valid;
  logic              row_ready;
  logic [IDX_W-1:0]  row_idx;
  logic [2:0]        row_q_count;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  writeback_pipe #(
    .DATA_W(DATA_W), .REG_W(REG_W), .IDX_W(IDX_W), .ROWQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pc_plus_8(in_pc_plus_8), .in_is_jal(in_is_jal),
    .in_we(in_we), .in_rd(in_rd),
    .in_send_row(in_send_row), .in_row_idx(in_row_idx),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
    .row_q_count(row_q_count)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic              we;
    logic              jal;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc8;
    logic              send;
    logic [IDX_W-1:0]  ridx;
    logic              rready;
    logic              e_we;
    logic [REG_W-1:0]  e_waddr;
    logic [DATA_W-1:0] e_wdata;
    logic [2:0]        e_cnt;
    logic              e_rv;
    logic [IDX_W-1:0]  e_ridx;
    logic              e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic e_we, input logic [REG_W-1:0] e_waddr,
                             input logic [DATA_W-1:0] e_wdata, input logic [2:0] e_cnt,
                             input logic e_rv, input logic [IDX_W-1:0] e_ridx, input logic e_rdy);
    chk({tag, "_rf_we"},    64'(rf_we),       64'(e_we));
    chk({tag, "_rf_waddr"}, 64'(rf_waddr),    64'(e_waddr));
    chk({tag, "_rf_wdata"}, 64'(rf_wdata),    64'(e_wdata));
    chk({tag, "_count"},    64'(row_q_count), 64'(e_cnt));
    chk({tag, "_row_valid"},64'(row_valid),   64'(e_rv));
    chk({tag, "_row_idx"},  64'(row_idx),     64'(e_ridx));
    chk({tag, "_in_ready"}, 64'(in_ready),    64'(e_rdy));
`ifdef WB_FWD_EN
    chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'(e_we));
    chk({tag, "_fwd_addr"},  64'(fwd_addr),  64'(e_waddr));
    chk({tag, "_fwd_data"},  64'(fwd_data),  64'(e_wdata));
`endif
  endtask

  task automatic drive(input logic v, input logic we, input logic jal, input logic [REG_W-1:0] rd,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] pc8,
                       input logic send, input logic [IDX_W-1:0] ridx, input logic rr);
    in_valid = v; in_we = we; in_is_jal = jal; in_rd = rd; in_data = d;
    in_pc_plus_8 = pc8; in_send_row = send; in_row_idx = ridx; row_ready = rr;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, '0, 0, '0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int                q[$];
  logic              m_we;
  logic [REG_W-1:0]  m_waddr;
  logic [DATA_W-1:0] m_wdata;

  initial begin
    rst = 1'b0;
    idle();

    // Reset: held for two edges, checked while still asserted.
    tick(); tick();
    check_state("reset", 0, '0, '0, 3'd0, 0, 5'h1F, 1);

    rst = 1'b1;
    vecs.push_back('{1,1,0,5'd3, 32'hDEADBEEF,32'h0,  0,5'd0,0, 1,5'd3, 32'hDEADBEEF,3'd0,0,5'h1F,1});
    vecs.push_back('{0,0,0,5'd0, 32'h0,       32'h0,  0,5'd0,0, 0,5'd3, 32'hDEADBEEF,3'd0,0,5'h1F,1});
    vecs.push_back('{1,1,1,5'd31,32'h55,      32'h108,0,5'd0,0, 1,5'd31,32'h108,     3'd0,0,5'h1F,1});
    vecs.push_back('{1,1,0,5'd0, 32'h1234,    32'h0,  0,5'd0,0, 0,5'd31,32'h108,     3'd0,0,5'h1F,1});
    vecs.push_back('{1,0,0,5'd0, 32'h0,       32'h0,  1,5'd1,0, 0,5'd31,32'h108,     3'd1,1,5'd1, 1});
    vecs.push_back('{1,0,0,5'd0, 32'h0,       32'h0,  1,5'd2,0, 0,5'd31,32'h108,     3'd2,1,5'd1, 1});
    vecs.push_back('{1,0,0,5'd0, 32'h0,       32'h0,  1,5'd3,0, 0,5'd31,32'h108,     3'd3,1,5'd1, 1});
    vecs.push_back('{1,0,0,5'd0, 32'h0,       32'h0,  1,5'd4,0, 0,5'd31,32'h108,     3'd4,1,5'd1, 0});
    // Full: this offer (write + push) must be refused while the pop happens.
    vecs.push_back('{1,1,0,5'd5, 32'h77,      32'h0,  1,5'd7,1, 0,5'd31,32'h108,     3'd3,1,5'd2, 1});
    vecs.push_back('{0,0,0,5'd0, 32'h0,       32'h0,  0,5'd0,0, 0,5'd31,32'h108,     3'd3,1,5'd2, 1});
    vecs.push_back('{0,0,0,5'd0, 32'h0,       32'h0,  0,5'd0,1, 0,5'd31,32'h108,     3'd2,1,5'd3, 1});
    vecs.push_back('{1,0,0,5'd0, 32'h0,       32'h0,  1,5'd9,1, 0,5'd31,32'h108,     3'd2,1,5'd4, 1});
    vecs.push_back('{0,0,0,5'd0, 32'h0,       32'h0,  0,5'd0,1, 0,5'd31,32'h108,     3'd1,1,5'd9, 1});
    vecs.push_back('{0,0,0,5'd0, 32'h0,       32'h0,  0,5'd0,1, 0,5'd31,32'h108,     3'd0,0,5'h1F,1});

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].we, vecs[i].jal, vecs[i].rd, vecs[i].data,
            vecs[i].pc8, vecs[i].send, vecs[i].ridx, vecs[i].rready);
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata,
                  vecs[i].e_cnt, vecs[i].e_rv, vecs[i].e_ridx, vecs[i].e_rdy);
    end

    // Pointer wrap: two entries, then ten push+pop rounds, then drain.
    drive(1, 0, 0, '0, '0, '0, 1, 5'd20, 0); tick();
    drive(1, 0, 0, '0, '0, '0, 1, 5'd21, 0); tick();
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 0, '0, '0, '0, 1, 5'(22 + k), 1); tick();
      check_state($sformatf("wrap%0d", k), 0, 5'd31, 32'h108, 3'd2, 1, 5'(21 + k), 1);
    end
    drive(0, 0, 0, '0, '0, '0, 0, '0, 1); tick();
    check_state("drain0", 0, 5'd31, 32'h108, 3'd1, 1, 5'd31, 1);
    tick();
    check_state("drain1", 0, 5'd31, 32'h108, 3'd0, 0, 5'h1F, 1);

    // Reset with three queued rows and a pending write; the accept and pop
    // offered during the reset edge are discarded.
    drive(1, 0, 0, '0, '0, '0, 1, 5'd5, 0); tick();
    drive(1, 0, 0, '0, '0, '0, 1, 5'd6, 0); tick();
    drive(1, 1, 0, 5'd4, 32'hAA, '0, 1, 5'd7, 0); tick();
    check_state("prerst", 1, 5'd4, 32'hAA, 3'd3, 1, 5'd5, 1);
    rst = 1'b0;
    drive(1, 1, 0, 5'd6, 32'hBB, '0, 1, 5'd8, 1); tick();
    check_state("midrst", 0, '0, '0, 3'd0, 0, 5'h1F, 1);
    rst = 1'b1;
    idle(); tick();
    check_state("postrst", 0, '0, '0, 3'd0, 0, 5'h1F, 1);

    // Randomized phase against the queue model.
    m_we = 0; m_waddr = '0; m_wdata = '0;
    for (int c = 0; c < 400; c++) begin
      logic acc, pop, r;
      r = ($urandom_range(0, 39) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            5'($urandom_range(0, 7) == 0 ? 0 : $urandom), 32'($urandom), 32'($urandom),
            $urandom_range(0, 2) != 0, 5'($urandom), $urandom_range(0, 2) == 0);
      rst = r;
      acc = in_valid && (q.size() < DEPTH);
      pop = (q.size() != 0) && row_ready;
      tick();
      if (!r) begin
        q.delete();
        m_we = 0; m_waddr = '0; m_wdata = '0;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc && in_send_row) q.push_back(int'(in_row_idx));
        m_we = acc && in_we && (in_rd != 0);
        if (m_we) begin
          m_waddr = in_rd;
          m_wdata = in_is_jal ? in_pc_plus_8 : in_data;
        end
      end
      check_state($sformatf("rnd%0d", c), m_we, m_waddr, m_wdata, 3'(q.size()),
                  q.size() != 0, (q.size() != 0) ? 5'(q[0]) : 5'h1F, q.size() < DEPTH);
    end
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
